// File: rtl/rc_mesh_adaptive_if.sv
// Flit stream bundle around the route-computation stage.
// The upstream side carries flits in from the input FIFO, the downstream side
// carries routed flits out to the switch allocator.
interface rc_mesh_adaptive_if #(
    parameter int DATASIZE = 40
);
    logic [DATASIZE-1:0] data_in;
    logic                valid_in;
    logic                in_ready;
    logic [DATASIZE-1:0] data_out;
    logic [3:0]          direction_out;
    logic                valid_out;
    logic                out_ready;
    logic                err_out;

    // Environment side: feeds flits in and accepts routed flits.
    modport master (
        output data_in, valid_in, out_ready,
        input  in_ready, data_out, direction_out, valid_out, err_out
    );

    // Route-computation stage side.
    modport slave (
        input  data_in, valid_in, out_ready,
        output in_ready, data_out, direction_out, valid_out, err_out
    );
endinterface

// File: rtl/rc_mesh_adaptive.sv
// Route computation for one input port of a 2D-mesh router.
// The head flit picks a minimal route, adaptively by downstream pressure or
// deterministically XY. Body and tail flits follow the route locked by their head.
module rc_mesh_adaptive #(
    parameter int DATASIZE  = 40,
    parameter int COORD_W   = 2,
    parameter int MESH_ROWS = 3,
    parameter int MESH_COLS = 3,
    parameter int ROW_POS   = 1,
    parameter int COL_POS   = 2,
    parameter int WIDTH     = 3
) (
    input  logic              rc_clk,
    input  logic              rst_n,
    rc_mesh_adaptive_if.slave bus,
    input  logic              mode_xy,
    input  logic [WIDTH:0]    N_pressure_in,
    input  logic [WIDTH:0]    E_pressure_in,
    input  logic [WIDTH:0]    S_pressure_in,
    input  logic [WIDTH:0]    W_pressure_in
);
    localparam logic [3:0] DIR_W     = 4'b1000;
    localparam logic [3:0] DIR_N     = 4'b0100;
    localparam logic [3:0] DIR_E     = 4'b0010;
    localparam logic [3:0] DIR_S     = 4'b0001;
    localparam logic [3:0] DIR_LOCAL = 4'b0000;
    localparam logic [3:0] DIR_NONE  = 4'b1111;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [COORD_W-1:0] ROW_C  = COORD_W'(ROW_POS);
    localparam logic [COORD_W-1:0] COL_C  = COORD_W'(COL_POS);
    localparam logic [COORD_W:0]   ROWS_C = (COORD_W+1)'(MESH_ROWS);
    localparam logic [COORD_W:0]   COLS_C = (COORD_W+1)'(MESH_COLS);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t         state_r, state_next_s;
    logic [3:0]          locked_dir_r, locked_dir_next_s;
    logic [DATASIZE-1:0] data_out_r;
    logic [3:0]          direction_out_r;
    logic                valid_out_r;
    logic                err_out_r;

    logic [COORD_W-1:0]  dst_row_s, dst_col_s;
    logic [1:0]          ftype_s;
    logic                dst_bad_s;
    logic [3:0]          horiz_dir_s, vert_dir_s, route_s;
    logic [WIDTH:0]      horiz_p_s, vert_p_s;
    logic [3:0]          dir_next_s;
    logic                err_next_s;
    logic                in_ready_s, in_xfer_s, out_xfer_s;

    assign in_ready_s = !valid_out_r | bus.out_ready;
    assign in_xfer_s  = bus.valid_in & in_ready_s;
    assign out_xfer_s = valid_out_r & bus.out_ready;

    assign bus.in_ready      = in_ready_s;
    assign bus.data_out      = data_out_r;
    assign bus.direction_out = direction_out_r;
    assign bus.valid_out     = valid_out_r;
    assign bus.err_out       = err_out_r;

    // Minimal route for the incoming flit's destination, plus range check.
    always_comb begin
        ftype_s   = bus.data_in[1:0];
        dst_row_s = bus.data_in[32+2*COORD_W-1:32+COORD_W];
        dst_col_s = bus.data_in[32+COORD_W-1:32];
        dst_bad_s = ({1'b0, dst_row_s} >= ROWS_C) || ({1'b0, dst_col_s} >= COLS_C);

        if (dst_col_s > COL_C) begin
            horiz_dir_s = DIR_E;
            horiz_p_s   = E_pressure_in;
        end else begin
            horiz_dir_s = DIR_W;
            horiz_p_s   = W_pressure_in;
        end

        if (dst_row_s > ROW_C) begin
            vert_dir_s = DIR_S;
            vert_p_s   = S_pressure_in;
        end else begin
            vert_dir_s = DIR_N;
            vert_p_s   = N_pressure_in;
        end

        // Ties go horizontal so adaptive mode degrades gracefully toward XY.
        if (dst_row_s == ROW_C && dst_col_s == COL_C) begin
            route_s = DIR_LOCAL;
        end else if (dst_row_s == ROW_C) begin
            route_s = horiz_dir_s;
        end else if (dst_col_s == COL_C) begin
            route_s = vert_dir_s;
        end else if (mode_xy) begin
            route_s = horiz_dir_s;
        end else if (horiz_p_s <= vert_p_s) begin
            route_s = horiz_dir_s;
        end else begin
            route_s = vert_dir_s;
        end
    end

    // Packet lock state register; cleared asynchronously by reset.
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_UNLOCKED;
            locked_dir_r <= DIR_NONE;
        end else begin
            state_r      <= state_next_s;
            locked_dir_r <= locked_dir_next_s;
        end
    end

    // Per-flit direction, error flag and next lock state.
    always_comb begin
        state_next_s      = state_r;
        locked_dir_next_s = locked_dir_r;
        dir_next_s        = DIR_NONE;
        err_next_s        = 1'b0;
        if (in_xfer_s) begin
            case (ftype_s)
                T_HEAD: begin
                    if (dst_bad_s) begin
                        err_next_s = 1'b1;
                    end else begin
                        dir_next_s        = route_s;
                        err_next_s        = (state_r == ST_LOCKED);
                        state_next_s      = ST_LOCKED;
                        locked_dir_next_s = route_s;
                    end
                end
                T_SINGLE: begin
                    dir_next_s = dst_bad_s ? DIR_NONE : route_s;
                    err_next_s = dst_bad_s | (state_r == ST_LOCKED);
                end
                T_BODY, T_TAIL: begin
                    if (state_r == ST_LOCKED) begin
                        dir_next_s = locked_dir_r;
                        if (ftype_s == T_TAIL) begin
                            state_next_s      = ST_UNLOCKED;
                            locked_dir_next_s = DIR_NONE;
                        end else begin
                            state_next_s      = ST_LOCKED;
                        end
                    end else begin
                        err_next_s = 1'b1;
                    end
                end
                default: begin
                    err_next_s = 1'b1;
                end
            endcase
        end else begin
            dir_next_s = DIR_NONE;
        end
    end

    // Registered output stage: load on accept, drain on hand-off, hold on stall.
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r      <= '0;
            direction_out_r <= DIR_NONE;
            valid_out_r     <= 1'b0;
            err_out_r       <= 1'b0;
        end else if (in_xfer_s) begin
            data_out_r      <= bus.data_in;
            direction_out_r <= dir_next_s;
            valid_out_r     <= 1'b1;
            err_out_r       <= err_next_s;
        end else if (out_xfer_s) begin
            direction_out_r <= DIR_NONE;
            valid_out_r     <= 1'b0;
            err_out_r       <= 1'b0;
        end else begin
            err_out_r       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rc_mesh_adaptive.sv
// Directed bench for rc_mesh_adaptive at router (row 1, col 2) of a 3x3 mesh.
module tb_rc_mesh_adaptive;
    logic       rc_clk;
    logic       rst_n;
    logic       mode_xy;
    logic [3:0] n_p, e_p, s_p, w_p;
    int         total;
    int         bad;

    rc_mesh_adaptive_if #(.DATASIZE(40)) bus();

    rc_mesh_adaptive #(
        .DATASIZE(40), .COORD_W(2), .MESH_ROWS(3), .MESH_COLS(3),
        .ROW_POS(1), .COL_POS(2), .WIDTH(3)
    ) dut (
        .rc_clk        (rc_clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .mode_xy       (mode_xy),
        .N_pressure_in (n_p),
        .E_pressure_in (e_p),
        .S_pressure_in (s_p),
        .W_pressure_in (w_p)
    );

    initial rc_clk = 1'b0;
    always #5 rc_clk = ~rc_clk;

    function automatic logic [39:0] mk(input logic [1:0] t, input logic [3:0] dst, input logic [29:0] d);
        return {4'h5, dst, d, t};
    endfunction

    // Present one flit for exactly one rising edge; returns #1 after that edge.
    task automatic send(input logic [39:0] f);
        @(negedge rc_clk);
        bus.data_in  = f;
        bus.valid_in = 1'b1;
        @(posedge rc_clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] f;
        // power-on reset state
        total++;
        if (bus.data_out !== 40'h0 || bus.direction_out !== 4'b1111 || bus.valid_out !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_init: got data=%h dir=%b v=%b rdy=%b want 0/1111/0/1",
                     bus.data_out, bus.direction_out, bus.valid_out, bus.in_ready);
        end
        // reset mid-packet while output is stalled
        mode_xy = 1'b0; w_p = 4'd1; s_p = 4'd4;
        send(mk(2'b01, 4'b1001, 30'h1));
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.data_out !== 40'h0 || bus.direction_out !== 4'b1111 || bus.valid_out !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: got data=%h dir=%b v=%b rdy=%b want 0/1111/0/1",
                     bus.data_out, bus.direction_out, bus.valid_out, bus.in_ready);
        end
        @(negedge rc_clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        // lock was dropped, so a body is now orphaned
        f = mk(2'b00, 4'b1001, 30'h2);
        send(f);
        total++;
        if (bus.direction_out !== 4'b1111 || bus.err_out !== 1'b1 || bus.data_out !== f) begin
            bad++;
            $display("FAIL reset_body_orphan: got dir=%b err=%b want 1111/1", bus.direction_out, bus.err_out);
        end
    endtask

    task automatic test_adaptive();
        mode_xy = 1'b0;
        w_p = 4'd3; n_p = 4'd3;
        send(mk(2'b11, 4'b0000, 30'h10));
        total++;
        if (bus.direction_out !== 4'b1000 || bus.valid_out !== 1'b1 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL adaptive_tie: got dir=%b v=%b err=%b want 1000/1/0", bus.direction_out, bus.valid_out, bus.err_out);
        end
        w_p = 4'd5; n_p = 4'd2;
        send(mk(2'b11, 4'b0000, 30'h11));
        total++;
        if (bus.direction_out !== 4'b0100) begin
            bad++;
            $display("FAIL adaptive_north: got dir=%b want 0100", bus.direction_out);
        end
        // drained with nothing new: output goes idle
        @(posedge rc_clk);
        #1;
        total++;
        if (bus.valid_out !== 1'b0 || bus.direction_out !== 4'b1111) begin
            bad++;
            $display("FAIL drain_idle: got v=%b dir=%b want 0/1111", bus.valid_out, bus.direction_out);
        end
    endtask

    task automatic test_xy();
        mode_xy = 1'b1;
        w_p = 4'd7; s_p = 4'd0;
        send(mk(2'b11, 4'b1000, 30'h20));
        total++;
        if (bus.direction_out !== 4'b1000) begin
            bad++;
            $display("FAIL xy_west: got dir=%b want 1000", bus.direction_out);
        end
        send(mk(2'b11, 4'b0110, 30'h21));
        total++;
        if (bus.direction_out !== 4'b0000 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL xy_local: got dir=%b err=%b want 0000/0", bus.direction_out, bus.err_out);
        end
        mode_xy = 1'b0;
    endtask

    task automatic test_packet_lock();
        mode_xy = 1'b0;
        w_p = 4'd1; s_p = 4'd4;
        send(mk(2'b01, 4'b1001, 30'h30));
        total++;
        if (bus.direction_out !== 4'b1000 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL lock_head: got dir=%b err=%b want 1000/0", bus.direction_out, bus.err_out);
        end
        w_p = 4'd7; s_p = 4'd0;
        mode_xy = 1'b1;
        send(mk(2'b00, 4'b1001, 30'h31));
        total++;
        if (bus.direction_out !== 4'b1000 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL lock_body: got dir=%b err=%b want 1000/0", bus.direction_out, bus.err_out);
        end
        mode_xy = 1'b0;
        send(mk(2'b10, 4'b1001, 30'h32));
        total++;
        if (bus.direction_out !== 4'b1000 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL lock_tail: got dir=%b err=%b want 1000/0", bus.direction_out, bus.err_out);
        end
        send(mk(2'b01, 4'b1001, 30'h33));
        total++;
        if (bus.direction_out !== 4'b0001 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL lock_next_head: got dir=%b err=%b want 0001/0", bus.direction_out, bus.err_out);
        end
        // head while locked: recomputed route, error, lock re-armed to west
        w_p = 4'd2; s_p = 4'd9;
        send(mk(2'b01, 4'b1001, 30'h34));
        total++;
        if (bus.direction_out !== 4'b1000 || bus.err_out !== 1'b1) begin
            bad++;
            $display("FAIL head_while_locked: got dir=%b err=%b want 1000/1", bus.direction_out, bus.err_out);
        end
        w_p = 4'd9; s_p = 4'd0;
        send(mk(2'b10, 4'b1001, 30'h35));
        total++;
        if (bus.direction_out !== 4'b1000 || bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL rearmed_tail: got dir=%b err=%b want 1000/0", bus.direction_out, bus.err_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] fa, fb;
        fa = mk(2'b11, 4'b0000, 30'h40);
        fb = mk(2'b11, 4'b0110, 30'h41);
        mode_xy = 1'b0; w_p = 4'd0; n_p = 4'd5;
        @(posedge rc_clk);
        @(negedge rc_clk);
        bus.out_ready = 1'b0;
        bus.data_in   = fa;
        bus.valid_in  = 1'b1;
        @(posedge rc_clk);
        #1;
        bus.data_in   = fb;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.in_ready !== 1'b0 || bus.valid_out !== 1'b1 || bus.data_out !== fa || bus.direction_out !== 4'b1000) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b data=%h dir=%b want 0/1/%h/1000",
                         i, bus.in_ready, bus.valid_out, bus.data_out, bus.direction_out, fa);
            end
            @(posedge rc_clk);
            #1;
        end
        @(negedge rc_clk);
        bus.out_ready = 1'b1;
        @(posedge rc_clk);
        #1;
        bus.valid_in = 1'b0;
        total++;
        if (bus.data_out !== fb || bus.valid_out !== 1'b1 || bus.direction_out !== 4'b0000) begin
            bad++;
            $display("FAIL stall_release: got data=%h v=%b dir=%b want %h/1/0000",
                     bus.data_out, bus.valid_out, bus.direction_out, fb);
        end
    endtask

    task automatic test_errors();
        logic [39:0] f;
        f = mk(2'b11, 4'b1111, 30'h50);
        send(f);
        total++;
        if (bus.direction_out !== 4'b1111 || bus.err_out !== 1'b1 || bus.valid_out !== 1'b1 || bus.data_out !== f) begin
            bad++;
            $display("FAIL err_bad_dst: got dir=%b err=%b v=%b want 1111/1/1", bus.direction_out, bus.err_out, bus.valid_out);
        end
        @(posedge rc_clk);
        #1;
        total++;
        if (bus.err_out !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse_width: got err=%b want 0", bus.err_out);
        end
        send(mk(2'b00, 4'b0000, 30'h51));
        total++;
        if (bus.direction_out !== 4'b1111 || bus.err_out !== 1'b1) begin
            bad++;
            $display("FAIL err_orphan_body: got dir=%b err=%b want 1111/1", bus.direction_out, bus.err_out);
        end
        // lock must still be clear: an orphan tail is also an error
        send(mk(2'b10, 4'b0000, 30'h52));
        total++;
        if (bus.direction_out !== 4'b1111 || bus.err_out !== 1'b1) begin
            bad++;
            $display("FAIL err_lock_clear: got dir=%b err=%b want 1111/1", bus.direction_out, bus.err_out);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        mode_xy = 1'b0;
        n_p = 4'd0; e_p = 4'd0; s_p = 4'd0; w_p = 4'd0;
        bus.data_in = 40'h0;
        bus.valid_in = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge rc_clk);
        #1;
        test_reset_pre();
        test_adaptive();
        test_xy();
        test_packet_lock();
        test_back_to_back();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Releases power-on reset, then runs the reset scenario.
    task automatic test_reset_pre();
        @(negedge rc_clk);
        rst_n = 1'b1;
        #1;
        test_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
